// File: rtl/pacman_cpu.sv
// pacman_cpu: single-cycle 32-bit RISC core for the Pacman game logic.
// Fetches from an external instruction ROM, accesses an external data RAM / game bus and
// drives an external 32x32 register file. lw takes two cycles (address, then write-back).
//
// Ports:
//   clock, reset                      clock and asynchronous active-high reset
//   address_imem / q_imem             instruction fetch (PC[11:0]) and instruction word
//   address_dmem, data, wren, q_dmem  data bus address, store data, write enable, load data
//   ctrl_writeEnable, ctrl_writeReg,
//   data_writeReg                     register-file write port
//   ctrl_readRegA/B, data_readRegA/B  register-file read ports
module pacman_cpu (
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] address_imem,
  input  logic [31:0] q_imem,
  output logic [16:0] address_dmem,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q_dmem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB
);

  localparam logic [4:0] OpRtype = 5'b00000;
  localparam logic [4:0] OpJ     = 5'b00001;
  localparam logic [4:0] OpBne   = 5'b00010;
  localparam logic [4:0] OpJal   = 5'b00011;
  localparam logic [4:0] OpJr    = 5'b00100;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpBlt   = 5'b00110;
  localparam logic [4:0] OpSw    = 5'b00111;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] OpSetx  = 5'b10101;
  localparam logic [4:0] OpBex   = 5'b10110;

  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluSub = 5'b00001;
  localparam logic [4:0] AluAnd = 5'b00010;
  localparam logic [4:0] AluOr  = 5'b00011;
  localparam logic [4:0] AluSll = 5'b00100;
  localparam logic [4:0] AluSra = 5'b00101;

  logic [31:0] pc_q, pc_d;
  logic        stall_q, stall_d;

  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] n_sext, t_zext, pc_inc;
  logic [31:0] add_res, sub_res, addi_res;
  logic        ovf_add, ovf_sub, ovf_addi;
  logic        we_raw;

  assign opcode = q_imem[31:27];
  assign rd     = q_imem[26:22];
  assign rs     = q_imem[21:17];
  assign rt     = q_imem[16:12];
  assign shamt  = q_imem[11:7];
  assign aluop  = q_imem[6:2];
  assign n_sext = {{15{q_imem[16]}}, q_imem[16:0]};
  assign t_zext = {5'd0, q_imem[26:0]};
  assign pc_inc = pc_q + 32'd1;

  assign add_res  = data_readRegA + data_readRegB;
  assign sub_res  = data_readRegA - data_readRegB;
  assign addi_res = data_readRegA + n_sext;

  // Two's complement overflow: operands' signs (after negation for sub) agree, result differs.
  assign ovf_add  = (data_readRegA[31] == data_readRegB[31]) &&
                    (add_res[31] != data_readRegA[31]);
  assign ovf_sub  = (data_readRegA[31] != data_readRegB[31]) &&
                    (sub_res[31] != data_readRegA[31]);
  assign ovf_addi = (data_readRegA[31] == n_sext[31]) && (addi_res[31] != data_readRegA[31]);

  assign address_imem = pc_q[11:0];
  assign address_dmem = addi_res[16:0];
  assign data         = data_readRegB;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= 32'd0;
      stall_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    pc_d          = pc_inc;
    stall_d       = 1'b0;
    we_raw        = 1'b0;
    ctrl_writeReg = rd;
    data_writeReg = 32'd0;
    ctrl_readRegA = rs;
    ctrl_readRegB = rt;
    wren          = 1'b0;

    case (opcode)
      OpRtype: begin
        case (aluop)
          AluAdd: begin
            we_raw = 1'b1;
            if (ovf_add) begin
              ctrl_writeReg = 5'd30;
              data_writeReg = 32'd1;
            end else begin
              data_writeReg = add_res;
            end
          end
          AluSub: begin
            we_raw = 1'b1;
            if (ovf_sub) begin
              ctrl_writeReg = 5'd30;
              data_writeReg = 32'd3;
            end else begin
              data_writeReg = sub_res;
            end
          end
          AluAnd: begin
            we_raw        = 1'b1;
            data_writeReg = data_readRegA & data_readRegB;
          end
          AluOr: begin
            we_raw        = 1'b1;
            data_writeReg = data_readRegA | data_readRegB;
          end
          AluSll: begin
            we_raw        = 1'b1;
            data_writeReg = data_readRegA << shamt;
          end
          AluSra: begin
            we_raw        = 1'b1;
            data_writeReg = $unsigned($signed(data_readRegA) >>> shamt);
          end
          default: ;
        endcase
      end
      OpAddi: begin
        we_raw = 1'b1;
        if (ovf_addi) begin
          ctrl_writeReg = 5'd30;
          data_writeReg = 32'd2;
        end else begin
          data_writeReg = addi_res;
        end
      end
      OpSw: begin
        ctrl_readRegB = rd;
        wren          = 1'b1;
      end
      OpLw: begin
        // First cycle presents the address and holds the PC; second cycle writes back.
        if (!stall_q) begin
          stall_d = 1'b1;
          pc_d    = pc_q;
        end else begin
          we_raw        = 1'b1;
          data_writeReg = q_dmem;
        end
      end
      OpJ: pc_d = t_zext;
      OpBne: begin
        ctrl_readRegB = rd;
        if (data_readRegB != data_readRegA) pc_d = pc_inc + n_sext;
      end
      OpBlt: begin
        ctrl_readRegB = rd;
        if ($signed(data_readRegB) < $signed(data_readRegA)) pc_d = pc_inc + n_sext;
      end
      OpJal: begin
        we_raw        = 1'b1;
        ctrl_writeReg = 5'd31;
        data_writeReg = pc_inc;
        pc_d          = t_zext;
      end
      OpJr: begin
        ctrl_readRegA = rd;
        pc_d          = data_readRegA;
      end
      OpBex: begin
        ctrl_readRegA = 5'd30;
        if (data_readRegA != 32'd0) pc_d = t_zext;
      end
      OpSetx: begin
        we_raw        = 1'b1;
        ctrl_writeReg = 5'd30;
        data_writeReg = t_zext;
      end
      default: ;
    endcase

    ctrl_writeEnable = we_raw && (ctrl_writeReg != 5'd0) && !reset;
    if (reset) wren = 1'b0;
  end

endmodule

// File: tb/tb_pacman_cpu.sv
// Testbench for pacman_cpu: combinational decode/ALU vectors driven directly onto the
// register read ports, then multi-cycle program sequences against a register-file,
// ROM and RAM model that sample on the falling edge.
module tb_pacman_cpu;

  logic        clock;
  logic        reset;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic [16:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  pacman_cpu dut (
    .clock            (clock),
    .reset            (reset),
    .address_imem     (address_imem),
    .q_imem           (q_imem),
    .address_dmem     (address_dmem),
    .data             (data),
    .wren             (wren),
    .q_dmem           (q_dmem),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Models of the external blocks.
  logic [31:0] regs [32];
  logic [31:0] rom  [4096];
  logic [31:0] ram  [4096];
  logic [31:0] bus_q;
  logic        use_tbl;
  logic [31:0] tbl_instr, tbl_a, tbl_b;

  always_comb begin
    q_imem        = use_tbl ? tbl_instr : rom[address_imem];
    data_readRegA = use_tbl ? tbl_a : regs[ctrl_readRegA];
    data_readRegB = use_tbl ? tbl_b : regs[ctrl_readRegB];
    q_dmem        = (address_dmem >= 17'd4096) ? bus_q : ram[address_dmem[11:0]];
  end

  always @(negedge clock) begin
    if (!use_tbl && ctrl_writeEnable) regs[ctrl_writeReg] = data_writeReg;
    if (!use_tbl && wren && address_dmem < 17'd4096) ram[address_dmem[11:0]] = data;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rd, rs, rt, sh, op);
    return {5'b00000, rd, rs, rt, sh, op, 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input logic [4:0] op, rd, rs, input logic [16:0] n);
    return {op, rd, rs, n};
  endfunction

  function automatic logic [31:0] j_type(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  rega;
    logic        chk_b;
    logic [4:0]  regb;
    logic        wren;
    logic [16:0] addr;
    logic [31:0] sdata;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr, a, b, input logic we,
                              input logic [4:0] wreg, input logic [31:0] wdata,
                              input logic [4:0] rega, input logic chk_b,
                              input logic [4:0] regb, input logic wr,
                              input logic [16:0] addr, input logic [31:0] sdata);
    vec_t v;
    v.instr = instr; v.a = a; v.b = b; v.we = we; v.wreg = wreg; v.wdata = wdata;
    v.rega = rega; v.chk_b = chk_b; v.regb = regb; v.wren = wr; v.addr = addr;
    v.sdata = sdata;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 32'd0;
      ram[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
  endtask

  // Holds reset over a rising edge, checks the forced outputs, then releases.
  task automatic do_reset();
    reset = 1'b1;
    step();
    check("rst_pc", {20'd0, address_imem}, 32'd0);
    check("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);
    reset = 1'b0;
    #1;
    check("first_fetch", {20'd0, address_imem}, 32'd0);
  endtask

  vec_t vecs[19];

  initial begin
    reset = 1'b1;
    use_tbl = 1'b0;
    tbl_instr = 32'd0; tbl_a = 32'd0; tbl_b = 32'd0;
    bus_q = 32'd0;
    clear_model();

    // instr, a, b, we, wreg, wdata, rega, chk_b, regb, wren, addr, sdata
    vecs[0]  = mk(r_type(3, 1, 2, 0, 0), 5, 7, 1, 3, 12, 1, 1, 2, 0, 0, 0);
    vecs[1]  = mk(r_type(3, 1, 2, 0, 1), 5, 7, 1, 3, 32'hFFFF_FFFE, 1, 1, 2, 0, 0, 0);
    vecs[2]  = mk(r_type(4, 1, 2, 0, 2), 32'hF0F0, 32'hFF00, 1, 4, 32'hF000, 1, 1, 2, 0, 0, 0);
    vecs[3]  = mk(r_type(4, 1, 2, 0, 3), 32'hF0F0, 32'hFF00, 1, 4, 32'hFFF0, 1, 1, 2, 0, 0, 0);
    vecs[4]  = mk(r_type(5, 1, 0, 4, 4), 32'h8000_0001, 0, 1, 5, 32'h0000_0010, 1, 1, 0, 0, 0, 0);
    vecs[5]  = mk(r_type(5, 1, 0, 4, 5), 32'h8000_0010, 0, 1, 5, 32'hF800_0001, 1, 1, 0, 0, 0, 0);
    vecs[6]  = mk(r_type(5, 1, 2, 0, 6), 5, 7, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    vecs[7]  = mk(i_type(5'b00101, 2, 1, 17'h1FFFD), 10, 0, 1, 2, 7, 1, 0, 0, 0, 0, 0);
    vecs[8]  = mk(r_type(3, 1, 2, 0, 0), 32'h7FFF_FFFF, 1, 1, 30, 1, 1, 1, 2, 0, 0, 0);
    vecs[9]  = mk(r_type(3, 1, 2, 0, 1), 32'h8000_0000, 1, 1, 30, 3, 1, 1, 2, 0, 0, 0);
    vecs[10] = mk(i_type(5'b00101, 2, 1, 17'd1), 32'h7FFF_FFFF, 0, 1, 30, 2, 1, 0, 0, 0, 0, 0);
    vecs[11] = mk(r_type(0, 1, 2, 0, 0), 5, 7, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    vecs[12] = mk(j_type(5'b10101, 27'd123), 0, 0, 1, 30, 123, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(i_type(5'b00111, 5, 1, 17'd4), 32'h1000, 240, 0, 0, 0, 1, 1, 5, 1, 4100, 240);
    vecs[14] = mk(i_type(5'b00010, 2, 1, 17'd3), 1, 2, 0, 0, 0, 1, 1, 2, 0, 0, 0);
    vecs[15] = mk(i_type(5'b00100, 31, 0, 17'd0), 4, 0, 0, 0, 0, 31, 0, 0, 0, 0, 0);
    vecs[16] = mk(j_type(5'b10110, 27'd20), 0, 0, 0, 0, 0, 30, 0, 0, 0, 0, 0);
    vecs[17] = mk(32'hF800_0000, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(r_type(3, 1, 2, 0, 1), 32'h8000_0000, 32'h8000_0000, 1, 3, 0, 1, 1, 2, 0, 0, 0);

    do_reset();

    // Combinational vectors; PC keeps running but no lw is applied here.
    use_tbl = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tbl_instr = vecs[i].instr;
      tbl_a     = vecs[i].a;
      tbl_b     = vecs[i].b;
      #2;
      check($sformatf("v%0d_we", i), {31'd0, ctrl_writeEnable}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        check($sformatf("v%0d_wreg", i), {27'd0, ctrl_writeReg}, {27'd0, vecs[i].wreg});
        check($sformatf("v%0d_wdata", i), data_writeReg, vecs[i].wdata);
      end
      check($sformatf("v%0d_rega", i), {27'd0, ctrl_readRegA}, {27'd0, vecs[i].rega});
      if (vecs[i].chk_b)
        check($sformatf("v%0d_regb", i), {27'd0, ctrl_readRegB}, {27'd0, vecs[i].regb});
      check($sformatf("v%0d_wren", i), {31'd0, wren}, {31'd0, vecs[i].wren});
      if (vecs[i].wren) begin
        check($sformatf("v%0d_addr", i), {15'd0, address_dmem}, {15'd0, vecs[i].addr});
        check($sformatf("v%0d_sdata", i), data, vecs[i].sdata);
      end
      #8;
    end
    use_tbl = 1'b0;

    // addi, addi, add; PC 0,1,2,3.
    clear_model();
    rom[0] = i_type(5'b00101, 1, 0, 17'd5);
    rom[1] = i_type(5'b00101, 2, 0, 17'd7);
    rom[2] = r_type(3, 1, 2, 0, 0);
    do_reset();
    step(); check("s1_pc1", {20'd0, address_imem}, 1);
    step(); check("s1_pc2", {20'd0, address_imem}, 2);
    step(); check("s1_pc3", {20'd0, address_imem}, 3);
    check("s1_r3", regs[3], 12);

    // lw from the game bus: address held two cycles, PC stalls one.
    clear_model();
    bus_q = 32'd2;
    rom[0] = i_type(5'b00101, 1, 0, 17'd4100);
    rom[1] = i_type(5'b01000, 4, 1, 17'd0);
    do_reset();
    step();
    check("lw1_pc", {20'd0, address_imem}, 1);
    check("lw1_addr", {15'd0, address_dmem}, 4100);
    check("lw1_we", {31'd0, ctrl_writeEnable}, 0);
    step();
    check("lw2_pc", {20'd0, address_imem}, 1);
    check("lw2_addr", {15'd0, address_dmem}, 4100);
    check("lw2_we", {31'd0, ctrl_writeEnable}, 1);
    check("lw2_wreg", {27'd0, ctrl_writeReg}, 4);
    check("lw2_wdata", data_writeReg, 2);
    step();
    check("lw_pc_next", {20'd0, address_imem}, 2);
    check("lw_r4", regs[4], 2);

    // sw to the game bus.
    clear_model();
    regs[5] = 32'd240;
    rom[0] = i_type(5'b00101, 1, 0, 17'd4200);
    rom[1] = i_type(5'b00111, 5, 1, 17'd0);
    do_reset();
    step();
    check("sw_wren", {31'd0, wren}, 1);
    check("sw_addr", {15'd0, address_dmem}, 4200);
    check("sw_data", data, 240);
    check("sw_we", {31'd0, ctrl_writeEnable}, 0);

    // add overflow then bex.
    clear_model();
    regs[1] = 32'h7FFF_FFFF;
    regs[2] = 32'h55;
    rom[0] = r_type(2, 1, 1, 0, 0);
    rom[1] = j_type(5'b10110, 27'd20);
    do_reset();
    step();
    check("ovf_r2", regs[2], 32'h55);
    check("ovf_r30", regs[30], 1);
    step();
    check("bex_pc", {20'd0, address_imem}, 20);

    // jal / jr.
    clear_model();
    rom[3]  = j_type(5'b00011, 27'd10);
    rom[10] = i_type(5'b00100, 31, 0, 17'd0);
    do_reset();
    step(); step(); step();
    check("jal_at3", {20'd0, address_imem}, 3);
    step();
    check("jal_pc", {20'd0, address_imem}, 10);
    check("jal_r31", regs[31], 4);
    step();
    check("jr_pc", {20'd0, address_imem}, 4);

    // blt taken / not taken.
    for (int k = 0; k < 2; k++) begin
      clear_model();
      regs[1] = (k == 0) ? 32'hFFFF_FFFF : 32'd3;
      regs[2] = 32'd3;
      rom[5] = i_type(5'b00110, 1, 2, 17'd2);
      do_reset();
      for (int s = 0; s < 5; s++) step();
      check($sformatf("blt%0d_at5", k), {20'd0, address_imem}, 5);
      step();
      check($sformatf("blt%0d_pc", k), {20'd0, address_imem}, (k == 0) ? 8 : 6);
    end

    // Reset during lw cycle 1.
    clear_model();
    regs[4] = 32'h1234;
    ram[100] = 32'h99;
    rom[0] = i_type(5'b00101, 1, 0, 17'd100);
    rom[1] = i_type(5'b01000, 4, 1, 17'd0);
    do_reset();
    step();
    check("rlw_at1", {20'd0, address_imem}, 1);
    #1 reset = 1'b1;
    #1;
    check("rlw_pc0", {20'd0, address_imem}, 0);
    check("rlw_we", {31'd0, ctrl_writeEnable}, 0);
    @(negedge clock);
    #1;
    check("rlw_r4", regs[4], 32'h1234);
    step();
    reset = 1'b0;
    step();
    check("rlw_restart", {20'd0, address_imem}, 1);
    check("rlw_r4_after", regs[4], 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
